// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two (4*NIBBLES)-bit unsigned operands one nibble
// per clock through a single shared 4-bit adder, LS nibble first, with
// valid/ready handshakes on both the operand and the result side.

module fourBitAdder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [4:0] s
);

   // 4-bit add with carry-out; this is the only adder in the datapath
   always_comb begin
      s = {1'b0, a} + {1'b0, b};
   end

endmodule

module nibble_serial_adder #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   in_a,
   input  logic [4*NIBBLES-1:0]   in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES:0]     out_sum,
   output logic                   busy
);

   localparam int unsigned W    = 4 * NIBBLES;
   localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    res_q, res_d;
   logic [W:0]      sum_q, sum_d;
   logic            carry_q, carry_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic            busy_q, busy_d;

   logic [4:0]      s5;
   logic [4:0]      nib_sum;

   fourBitAdder u_add (
      .a (a_q[3:0]),
      .b (b_q[3:0]),
      .s (s5)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = sum_q;
   assign busy      = busy_q;

   // Next-state and datapath: accept operands, step one nibble per cycle, hold result
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      sum_d       = sum_q;
      carry_d     = carry_q;
      idx_d       = idx_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      nib_sum     = s5 + {4'b0, carry_q};

      case (state_q)
         S_IDLE: begin
            in_ready_d = 1'b1;
            if (in_valid && in_ready_q) begin
               a_d        = in_a;
               b_d        = in_b;
               carry_d    = 1'b0;
               idx_d      = '0;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            for (int unsigned i = 0; i < NIBBLES; i++) begin
               if (idx_q == IDXW'(i)) begin
                  res_d[4*i +: 4] = nib_sum[3:0];
               end
            end
            carry_d = nib_sum[4];
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            idx_d   = idx_q + IDXW'(1);
            if (idx_q == IDX_LAST) begin
               sum_d       = {nib_sum[4], res_d};
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         idx_q       <= idx_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4): a transaction-level
// model (sum = a + b, ready after NIBBLES cycles) checked every cycle, plus
// hand-computed literal sums for directed vectors.

module tb_nibble_serial_adder;

   localparam int unsigned NIBBLES = 4;
   localparam int unsigned W       = 4 * NIBBLES;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W:0]    out_sum;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [W:0] got[$];
   int         acc_q[$];

   nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transaction model: a pending sum appears NIBBLES cycles after acceptance
   logic       m_ready = 1'b0;
   logic       m_valid = 1'b0;
   logic       m_busy  = 1'b0;
   logic       m_run   = 1'b0;
   logic [W:0] m_sum   = '0;
   logic [W:0] m_pend  = '0;
   int         m_cnt   = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ready = 1'b0; m_valid = 1'b0; m_busy = 1'b0; m_run = 1'b0;
         m_sum = '0; m_cnt = 0;
      end else if (m_valid) begin
         if (out_ready) begin
            m_valid = 1'b0; m_busy = 1'b0; m_ready = 1'b1;
         end
      end else if (m_run) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_run = 1'b0; m_valid = 1'b1; m_sum = m_pend;
         end
      end else if (m_ready && in_valid) begin
         m_pend  = {1'b0, in_a} + {1'b0, in_b};
         m_run   = 1'b1;
         m_cnt   = NIBBLES;
         m_ready = 1'b0;
         m_busy  = 1'b1;
      end else begin
         m_ready = 1'b1;
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      chk("in_ready",  in_ready,  m_ready);
      chk("out_valid", out_valid, m_valid);
      chk("busy",      busy,      m_busy);
      chk("out_sum",   out_sum,   m_sum);
      if (out_valid && out_ready) got.push_back(out_sum);
      if (in_valid && in_ready && !rst) acc_q.push_back(cyc + 1);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
      bit ok = 1'b0;
      in_a = a; in_b = b; in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      chk("accept_timeout", ok, 1);
      tick();
      acc = cyc;
      in_valid = 1'b0;
      in_a = W'($urandom);
      in_b = W'($urandom);
   endtask

   task automatic wait_valid(output int at);
      bit ok = 1'b0;
      at = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1'b1; at = cyc; break; end
      end
      chk("result_timeout", ok, 1);
   endtask

   task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W:0] exp);
      int acc, vat, n0;
      n0 = got.size();
      out_ready = 1'b1;
      send(a, b, acc);
      wait_valid(vat);
      chk({name, "_latency"}, vat - acc, NIBBLES);
      tick();
      chk({name, "_count"}, got.size(), n0 + 1);
      if (got.size() > 0) chk(name, got[got.size()-1], exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, vat, n0;
      bit ok;

      // Reset with in_valid held high
      #1 rst = 1'b1; in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_sum",  out_sum,  0);
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("rel_ready_pre_edge", in_ready, 0);
      @(negedge clk);
      chk("rel_ready_post_edge", in_ready, 1);
      chk("rst_no_result", got.size(), 0);
      tick();

      // Basic sums, carry ripple and maximum
      op("sum_zero",   16'h0000, 16'h0000, 17'h00000);
      op("sum_basic",  16'h1234, 16'h0F0F, 17'h02143);
      op("sum_ripple", 16'hFFFF, 16'h0001, 17'h10000);
      op("sum_max",    16'hFFFF, 16'hFFFF, 17'h1FFFE);

      // Backpressure: DONE held for 5 cycles while inputs churn
      out_ready = 1'b0;
      n0 = got.size();
      send(16'hABCD, 16'h1357, acc);
      wait_valid(vat);
      for (int i = 0; i < 5; i++) begin
         tick();
         in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
         @(negedge clk);
         chk("bp_sum",      out_sum,   17'h0BF24);
         chk("bp_in_ready", in_ready,  0);
         chk("bp_busy",     busy,      1);
         chk("bp_valid",    out_valid, 1);
      end
      tick();
      out_ready = 1'b1; in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("bp_ready_after", in_ready,  1);
      chk("bp_valid_after", out_valid, 0);
      chk("bp_single",      got.size(), n0 + 1);
      if (got.size() > 0) chk("bp_result", got[got.size()-1], 17'h0BF24);
      tick();

      // Back-to-back: three queued pairs with in_valid/out_ready held high
      n0 = acc_q.size();
      begin
         logic [W-1:0] pa[3] = '{16'h0001, 16'h8000, 16'h7FFF};
         logic [W-1:0] pb[3] = '{16'h0001, 16'h8000, 16'h0001};
         logic [W:0]   ps[3] = '{17'h00002, 17'h10000, 17'h08000};
         int g0;
         g0 = got.size();
         in_a = pa[0]; in_b = pb[0]; in_valid = 1'b1;
         for (int k = 0; k < 3; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
               @(negedge clk);
               if (in_ready) begin ok = 1'b1; break; end
            end
            chk("b2b_accept_timeout", ok, 1);
            tick();
            if (k < 2) begin
               in_a = pa[k+1]; in_b = pb[k+1];
            end else begin
               in_valid = 1'b0;
            end
         end
         ok = 1'b0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (got.size() >= g0 + 3) begin ok = 1'b1; break; end
         end
         chk("b2b_result_timeout", ok, 1);
         tick();
         chk("b2b_accepts", acc_q.size(), n0 + 3);
         if (acc_q.size() >= n0 + 3) begin
            chk("b2b_gap1", acc_q[n0+1] - acc_q[n0],   6);
            chk("b2b_gap2", acc_q[n0+2] - acc_q[n0+1], 6);
         end
         if (got.size() >= g0 + 3) begin
            for (int k = 0; k < 3; k++) chk("b2b_sum", got[g0+k], ps[k]);
         end
      end

      // Reset asserted between edges while idx=2 of 0xFFFF+0xFFFF
      n0 = got.size();
      out_ready = 1'b1;
      send(16'hFFFF, 16'hFFFF, acc);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      @(negedge clk);
      chk("abort_valid", out_valid, 0);
      chk("abort_sum",   out_sum,   0);
      chk("abort_busy",  busy,      0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("abort_no_result", got.size(), n0);
      chk("abort_sum_held",  out_sum,    0);
      op("sum_after_abort", 16'h0001, 16'h0002, 17'h00003);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle sequencer that adds two (4·NIBBLES)-bit unsigned operands using a single shared `fourBitAdder` instance, one nibble per clock, least-significant nibble first. It provides a valid/ready handshake on both sides and sits between a requester and any consumer of wide sums. It trades latency for area: one 4-bit adder plus a carry flop replaces a full-width ripple adder.

## Interface
- NIBBLES, default 4: operand width in nibbles (W = 4·NIBBLES); legal range 1..16.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  requester presents operands.
- in_ready  output  1  block accepts operands; a transfer occurs on an edge with in_valid && in_ready.
- in_a  input  W  operand A, sampled only on the transfer edge.
- in_b  input  W  operand B, sampled only on the transfer edge.
- out_valid  output  1  out_sum holds a completed result.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  W+1  {carry_out, sum}, unsigned.
- busy  output  1  high from the acceptance edge until the result transfer edge.

## Operation
- One clock domain. rst is asynchronous and active-high.
- All outputs are registered.
- FSM states:
  - IDLE: in_ready=1; waits for in_valid.
  - RUN: processes nibble idx = 0..NIBBLES-1, one per cycle.
  - DONE: out_valid=1; waits for out_ready.
- IDLE→RUN on in_valid && in_ready:
  - latch in_a and in_b into operand shift registers;
  - carry←0, idx←0;
  - in_ready←0, busy←1.
- RUN, each edge:
  - the fourBitAdder receives the current low nibbles a_n and b_n and produces 5-bit s5 (0..30);
  - nib_sum = s5 + carry, a 5-bit result in 0..31;
  - result[4·idx+3:4·idx] ← nib_sum[3:0], carry ← nib_sum[4];
  - operand registers shift right by 4; idx++.
- RUN→DONE on the edge that processes idx = NIBBLES-1:
  - out_sum ← {final carry, result}; out_valid ← 1.
- DONE→IDLE on out_valid && out_ready:
  - out_valid←0, busy←0, in_ready←1.
- in_valid is ignored outside IDLE. Operand inputs may change freely after the acceptance edge.
- out_sum changes only on the RUN→DONE edge. It holds its value through DONE and the following IDLE/RUN, until the next completion.
- The carry-out of the final nibble is bit W of out_sum. Nothing wraps or saturates: the maximum result is 2·(2^W−1).
- Reset values: state IDLE, in_ready 0, out_valid 0, busy 0, out_sum 0, carry 0, idx 0.
- After rst deasserts, in_ready rises on the first clock edge.
- Reset asserted mid-RUN or in DONE aborts the operation immediately. No partial result is ever presented.

## Timing
- Acceptance edge t. RUN edges are t+1 .. t+NIBBLES. out_valid is high after edge t+NIBBLES: latency is NIBBLES cycles.
- With out_ready held high, the result transfers on edge t+NIBBLES+1, in_ready returns high on that same edge, and the next acceptance is possible at t+NIBBLES+2.
- Minimum initiation interval: NIBBLES+2 cycles.
- No combinational path from any input to any output.
- out_ready low in DONE stalls indefinitely; out_sum, out_valid and busy stay constant during the stall.
- Critical path: 4-bit ripple plus 5-bit carry increment, independent of NIBBLES.

## Test plan
All scenarios use NIBBLES=4.
- Reset/idle:
  - Stimulus: assert rst for 3 cycles with in_valid=1, then release.
  - Required: all outputs 0 during reset; in_ready=1 one edge after release; no transfer while rst is high.
- Basic sums:
  - Stimulus: 0x0000+0x0000, then 0x1234+0x0F0F.
  - Required: out_sum = 0x00000 and 0x02143 respectively; out_valid exactly 4 cycles after each acceptance.
- Carry ripple and max:
  - Stimulus: 0xFFFF+0x0001, then 0xFFFF+0xFFFF.
  - Required: out_sum = 0x10000 and 0x1FFFE; the carry propagates through all four nibbles.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE, changing in_a and in_b and holding in_valid=1.
  - Required: out_sum stable, in_ready=0, busy=1; a single transfer when out_ready rises; in_ready=1 on that edge.
- Back-to-back:
  - Stimulus: in_valid and out_ready held high with 3 queued operand pairs.
  - Required: acceptances spaced exactly 6 cycles apart; results delivered in order and correct.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously (between edges) at idx=2 of 0xFFFF+0xFFFF.
  - Required: out_valid never asserts for that operation; out_sum=0; after release, 0x0001+0x0002 yields 0x00003.
